// File: rtl/trigger_stages.sv
// trigger_stages: parametrised multi-stage serial trigger producing run/capture from a sample stream
module trigger_stages #(
  parameter int WIDTH   = 32,
  parameter int STAGES  = 4,
  parameter int DELAY_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              finish_now,
  input  logic              validIn,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic [STAGES-1:0] wrMask,
  input  logic [STAGES-1:0] wrValue,
  input  logic [STAGES-1:0] wrConfig,
  input  logic [WIDTH-1:0]  config_data,
  output logic              run,
  output logic              capture,
  output logic              armed,
  output logic [3:0]        level
);
  typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mask [STAGES];
  logic [WIDTH-1:0] value [STAGES];
  logic [DELAY_W-1:0] dly [STAGES];
  logic [3:0] lvl [STAGES];
  logic [STAGES-1:0] en, st, edg, prev, raw, hit;
  logic [DELAY_W-1:0] cnt, sel_delay;
  logic pending, pend_start, eval, any_hit, sel_start, act, act_start, fire;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        mask[k] <= '0;
        value[k] <= '0;
        dly[k] <= '0;
        lvl[k] <= '0;
      end
      en <= '0;
      st <= '0;
      edg <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (wrMask[k]) mask[k] <= config_data;
        if (wrValue[k]) value[k] <= config_data;
        if (wrConfig[k]) begin
          dly[k] <= config_data[DELAY_W-1:0];
          lvl[k] <= config_data[19:16];
          edg[k] <= config_data[26];
          st[k] <= config_data[27];
          en[k] <= config_data[31];
        end
      end
    end
  // lowest-index hit wins, so scan downward and let lower stages overwrite
  always_comb begin
    raw = '0;
    hit = '0;
    any_hit = 1'b0;
    sel_start = 1'b0;
    sel_delay = '0;
    for (int k = 0; k < STAGES; k++) begin
      raw[k] = ((dataIn ^ value[k]) & mask[k]) == '0;
      hit[k] = en[k] && lvl[k] == level && raw[k] && !(edg[k] && prev[k]);
    end
    for (int k = STAGES - 1; k >= 0; k--)
      if (hit[k]) begin
        any_hit = 1'b1;
        sel_start = st[k];
        sel_delay = dly[k];
      end
  end
  assign eval = state == ARMED && validIn && !arm;
  assign act = eval && (pending ? cnt == DELAY_W'(1) : any_hit && sel_delay == '0);
  assign act_start = pending ? pend_start : sel_start;
  assign fire = state == ARMED && !arm && (finish_now || (act && act_start));
  assign armed = state == ARMED;
  always_comb state_nx = arm ? ARMED : fire ? FIRED : state;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      run <= 1'b0;
      capture <= 1'b0;
      level <= '0;
      cnt <= '0;
      pending <= 1'b0;
      pend_start <= 1'b0;
      prev <= '0;
    end else begin
      run <= fire;
      capture <= validIn && !arm && state != IDLE;
      if (arm) begin
        level <= '0;
        cnt <= '0;
        pending <= 1'b0;
        prev <= '0;
      end else begin
        if (eval) begin
          prev <= raw;
          if (pending) begin
            cnt <= cnt - 1'b1;
            pending <= cnt != DELAY_W'(1);
          end else if (any_hit && sel_delay != '0) begin
            cnt <= sel_delay;
            pending <= 1'b1;
            pend_start <= sel_start;
          end
        end
        if (act && !fire && level != 4'hf) level <= level + 4'd1;
      end
    end
endmodule
